// File: rtl/dot_product_sequencer.sv
//------------------------------------------------------------------------------
// dot_product_sequencer : sequences an N-element FP32 dot product over a shared
//                         stb/ack multiplier and adder.      Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dot_product_sequencer #(
  parameter int N              = 4,
  parameter int ELEMENT_LENGTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [N*ELEMENT_LENGTH-1:0] vec_a,
  input  logic [N*ELEMENT_LENGTH-1:0] vec_b,
  input  logic                        out_ack,
  output logic [31:0]                 result,
  output logic                        out_ready,
  output logic                        busy,
  // shared multiplier
  output logic [31:0]                 mul_a,
  output logic [31:0]                 mul_b,
  output logic                        mul_a_stb,
  output logic                        mul_b_stb,
  input  logic                        mul_a_ack,
  input  logic                        mul_b_ack,
  input  logic [31:0]                 mul_z,
  input  logic                        mul_z_stb,
  output logic                        mul_z_ack,
  // shared adder
  output logic [31:0]                 add_a,
  output logic [31:0]                 add_b,
  output logic                        add_a_stb,
  output logic                        add_b_stb,
  input  logic                        add_a_ack,
  input  logic                        add_b_ack,
  input  logic [31:0]                 add_z,
  input  logic                        add_z_stb,
  output logic                        add_z_ack
);

  localparam int W     = ELEMENT_LENGTH;
  localparam int VW    = N * W;
  localparam int IDX_W = $clog2(N) + 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MUL_ISSUE = 3'd1,
    MUL_WAIT  = 3'd2,
    ADD_ISSUE = 3'd3,
    ADD_WAIT  = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t           state;
  logic [VW-1:0]    cap_a;
  logic [VW-1:0]    cap_b;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     acc;
  logic [W-1:0]     prod;

  // Element 0 sits in the MSBs of a packed vector.
  function automatic logic [W-1:0] element(input logic [VW-1:0] v,
                                           input logic [IDX_W-1:0] k);
    logic [W-1:0] e;
    e = '0;
    for (int i = 0; i < N; i++) begin
      if (k == IDX_W'(i)) e = v[VW-1-W*i -: W];
    end
    return e;
  endfunction

  // The adder operands are the prod/acc registers themselves, so they stay
  // registered and cannot drift from the values being accumulated.
  assign add_a = prod;
  assign add_b = acc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cap_a     <= '0;
      cap_b     <= '0;
      idx       <= '0;
      acc       <= '0;
      prod      <= '0;
      result    <= '0;
      out_ready <= 1'b0;
      busy      <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_a_stb <= 1'b0;
      mul_b_stb <= 1'b0;
      mul_z_ack <= 1'b0;
      add_a_stb <= 1'b0;
      add_b_stb <= 1'b0;
      add_z_ack <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            cap_a     <= vec_a;
            cap_b     <= vec_b;
            acc       <= '0;
            idx       <= '0;
            mul_a     <= vec_a[VW-1 -: W];
            mul_b     <= vec_b[VW-1 -: W];
            mul_a_stb <= 1'b1;
            mul_b_stb <= 1'b1;
            busy      <= 1'b1;
            state     <= MUL_ISSUE;
          end
        end

        MUL_ISSUE: begin
          // Each operand drops its strobe independently on its own transfer.
          if (mul_a_stb && mul_a_ack) mul_a_stb <= 1'b0;
          if (mul_b_stb && mul_b_ack) mul_b_stb <= 1'b0;
          if ((!mul_a_stb || mul_a_ack) && (!mul_b_stb || mul_b_ack)) begin
            mul_a_stb <= 1'b0;
            mul_b_stb <= 1'b0;
            mul_z_ack <= 1'b1;
            state     <= MUL_WAIT;
          end
        end

        MUL_WAIT: begin
          if (mul_z_stb) begin
            prod      <= mul_z;
            mul_z_ack <= 1'b0;
            add_a_stb <= 1'b1;
            add_b_stb <= 1'b1;
            state     <= ADD_ISSUE;
          end
        end

        ADD_ISSUE: begin
          if (add_a_stb && add_a_ack) add_a_stb <= 1'b0;
          if (add_b_stb && add_b_ack) add_b_stb <= 1'b0;
          if ((!add_a_stb || add_a_ack) && (!add_b_stb || add_b_ack)) begin
            add_a_stb <= 1'b0;
            add_b_stb <= 1'b0;
            add_z_ack <= 1'b1;
            state     <= ADD_WAIT;
          end
        end

        ADD_WAIT: begin
          if (add_z_stb) begin
            acc       <= add_z;
            add_z_ack <= 1'b0;
            if (idx == IDX_LAST) begin
              result    <= add_z;
              out_ready <= 1'b1;
              state     <= DONE;
            end else begin
              idx       <= idx + IDX_ONE;
              mul_a     <= element(cap_a, idx + IDX_ONE);
              mul_b     <= element(cap_b, idx + IDX_ONE);
              mul_a_stb <= 1'b1;
              mul_b_stb <= 1'b1;
              state     <= MUL_ISSUE;
            end
          end
        end

        DONE: begin
          // A load arriving together with out_ack is deliberately dropped.
          if (out_ack) begin
            out_ready <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
